mc_core_hs: RTL and testbench

// Parametrised multi-cycle MIPS-subset core: register file, ALU, IR/A/B/ALUOut/data registers and control FSM in one block.

---
 rtl/mc_core_hs_if.sv | 26 ++
 rtl/mc_core_hs.sv | 237 +++++++++++++++++++++++
 tb/tb_mc_core_hs.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_core_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_core_hs_if
// Description : Unified memory port of the multi-cycle core. The core issues
//               a request and holds it stable until the memory returns ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_core_hs_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mc_core_hs.sv
`default_nettype none
// ============================================================================
// Module      : mc_core_hs
// Description : Multi-cycle MIPS-subset core (lw, sw, beq, addi, j, add, sub,
//               and, or, slt) with a single req/ready memory port, an
//               illegal-opcode halt and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_core_hs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32,
    parameter bit          HALT_ILL = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mc_core_hs_if.master          mem,
    output logic [31:0]           pc,
    output logic                  halted,
    output logic [CNT_W-1:0]      instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    // Where an unsupported opcode/funct sends the machine.
    localparam state_t           c_ILL_STATE = HALT_ILL ? S_HALT : S_FETCH;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       data_q, data_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [31:0]       rf_q [32];

    logic              w_rf_we;
    logic [4:0]        w_rf_wa;
    logic [31:0]       w_rf_wd;
    logic              w_req;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [31:0]       w_alu_res;
    logic              w_alu_ok;

    wire logic [5:0]  w_op     = ir_q[31:26];
    wire logic [4:0]  w_rs     = ir_q[25:21];
    wire logic [4:0]  w_rt     = ir_q[20:16];
    wire logic [4:0]  w_rd     = ir_q[15:11];
    wire logic [5:0]  w_funct  = ir_q[5:0];
    wire logic [31:0] w_simm   = {{16{ir_q[15]}}, ir_q[15:0]};
    wire logic [31:0] w_rs_val = (w_rs == 5'd0) ? 32'd0 : rf_q[w_rs];
    wire logic [31:0] w_rt_val = (w_rt == 5'd0) ? 32'd0 : rf_q[w_rt];

    // R-type ALU; flags funct codes outside the supported set.
    always_comb begin
        w_alu_res = 32'd0;
        w_alu_ok  = 1'b1;
        case (w_funct)
            c_FN_ADD: w_alu_res = a_q + b_q;
            c_FN_SUB: w_alu_res = a_q - b_q;
            c_FN_AND: w_alu_res = a_q & b_q;
            c_FN_OR:  w_alu_res = a_q | b_q;
            c_FN_SLT: w_alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
            default:  w_alu_ok  = 1'b0;
        endcase
    end

    // Control FSM: next state, datapath register updates and memory port drive.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        data_d    = data_q;
        instret_d = instret_q;
        w_rf_we   = 1'b0;
        w_rf_wa   = 5'd0;
        w_rf_wd   = 32'd0;
        w_req     = 1'b0;
        w_we      = 1'b0;
        w_addr    = {pc_q[31:2], 2'b00};
        w_wdata   = 32'd0;
        case (state_q)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = w_rs_val;
                b_d   = w_rt_val;
                alu_d = pc_q + (w_simm << 2);
                case (w_op)
                    c_OP_LW, c_OP_SW: state_d = S_MEMADR;
                    c_OP_RTYPE:       state_d = S_EXEC;
                    c_OP_BEQ:         state_d = S_BRANCH;
                    c_OP_ADDI:        state_d = S_ADDIEX;
                    c_OP_J:           state_d = S_JUMP;
                    default: begin
                        state_d = c_ILL_STATE;
                        if (!HALT_ILL) instret_d = instret_q + c_CNT_ONE;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_d   = a_q + w_simm;
                state_d = (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_req  = 1'b1;
                w_addr = {alu_q[31:2], 2'b00};
                if (mem.mem_ready) begin
                    data_d  = mem.mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_rf_we   = 1'b1;
                w_rf_wa   = w_rt;
                w_rf_wd   = data_q;
                instret_d = instret_q + c_CNT_ONE;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = {alu_q[31:2], 2'b00};
                w_wdata = b_q;
                if (mem.mem_ready) begin
                    instret_d = instret_q + c_CNT_ONE;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_d = w_alu_res;
                if (w_alu_ok) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = c_ILL_STATE;
                    if (!HALT_ILL) instret_d = instret_q + c_CNT_ONE;
                end
            end
            S_ALUWB: begin
                w_rf_we   = 1'b1;
                w_rf_wa   = w_rd;
                w_rf_wd   = alu_q;
                instret_d = instret_q + c_CNT_ONE;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_q;
                instret_d = instret_q + c_CNT_ONE;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_d   = a_q + w_simm;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_rf_we   = 1'b1;
                w_rf_wa   = w_rt;
                w_rf_wd   = alu_q;
                instret_d = instret_q + c_CNT_ONE;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
                instret_d = instret_q + c_CNT_ONE;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers; the register file is deliberately not reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_q     <= 32'd0;
            data_q    <= 32'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            data_q    <= data_d;
            instret_q <= instret_d;
        end
    end

    // Register file write port; r0 is never written and always reads as zero.
    always_ff @(posedge clk) begin
        if (w_rf_we && (w_rf_wa != 5'd0)) rf_q[w_rf_wa] <= w_rf_wd;
    end

    // The request is gated by reset so an in-flight access is dropped at once.
    assign mem.mem_req   = w_req & ~reset;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_wdata = w_wdata;
    assign pc            = pc_q;
    assign halted        = (state_q == S_HALT);
    assign instret       = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_core_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_core_hs
// Description : Bench for mc_core_hs. An instruction-level model executes each
//               program and queues every memory access it implies; a monitor
//               pops and compares whenever the core completes an access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_core_hs;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam bit [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam bit [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef struct packed {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] instret;

    mc_core_hs_if mif();

    mc_core_hs #(.RESET_PC(RST_PC), .CNT_W(32), .HALT_ILL(1'b1)) dut (
        .clk(clk), .reset(reset), .mem(mif), .pc(pc), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    acc_t         exp_q[$];
    bit [31:0]    mem     [bit [29:0]];
    bit [31:0]    ref_mem [bit [29:0]];
    bit [31:0]    prog[$];
    int           max_wait = 0;
    int           exp_ret;
    bit [31:0]    exp_pc;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] enc_r(bit [5:0] fn, int rd, int rs, int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction
    function automatic bit [31:0] enc_i(bit [5:0] op, int rt, int rs, bit [31:0] imm);
        return {op, 5'(rs), 5'(rt), imm[15:0]};
    endfunction
    function automatic bit [31:0] enc_j(bit [31:0] tgt);
        return {OP_J, tgt[27:2]};
    endfunction

    function automatic bit [31:0] ref_rd(bit [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'd0;
    endfunction

    // Instruction-level reference: run the loaded program to its halt.
    task automatic ref_run();
        bit [31:0] regs[32];
        bit [31:0] p, ir, npc, imm, ea, res;
        int        rs, rt, rd;
        bit        stop;
        foreach (regs[i]) regs[i] = 32'd0;
        p = RST_PC; exp_ret = 0; exp_pc = 32'd0;
        for (int step = 0; step < 4000; step++) begin
            exp_q.push_back('{1'b0, p, 32'd0});
            ir  = ref_rd(p);
            npc = p + 32'd4;
            imm = {{16{ir[15]}}, ir[15:0]};
            rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
            stop = 1'b0; res = 32'd0;
            case (ir[31:26])
                6'h00: begin
                    case (ir[5:0])
                        FN_ADD: res = regs[rs] + regs[rt];
                        FN_SUB: res = regs[rs] - regs[rt];
                        FN_AND: res = regs[rs] & regs[rt];
                        FN_OR:  res = regs[rs] | regs[rt];
                        FN_SLT: res = ($signed(regs[rs]) < $signed(regs[rt])) ? 32'd1 : 32'd0;
                        default: stop = 1'b1;
                    endcase
                    if (!stop && rd != 0) regs[rd] = res;
                end
                OP_LW: begin
                    ea = (regs[rs] + imm) & 32'hFFFF_FFFC;
                    exp_q.push_back('{1'b0, ea, 32'd0});
                    if (rt != 0) regs[rt] = ref_rd(ea);
                end
                OP_SW: begin
                    ea = (regs[rs] + imm) & 32'hFFFF_FFFC;
                    exp_q.push_back('{1'b1, ea, regs[rt]});
                    ref_mem[ea[31:2]] = regs[rt];
                end
                OP_BEQ:  if (regs[rs] == regs[rt]) npc = npc + (imm << 2);
                OP_ADDI: if (rt != 0) regs[rt] = regs[rs] + imm;
                OP_J:    npc = {npc[31:28], ir[25:0], 2'b00};
                default: stop = 1'b1;
            endcase
            if (stop) begin
                exp_pc = p + 32'd4;
                break;
            end
            exp_ret++;
            p = npc;
        end
    endtask

    task automatic load_prog();
        bit [31:0] a;
        for (int i = 0; i < prog.size(); i++) begin
            a = RST_PC + 32'(4 * i);
            mem[a[31:2]] = prog[i];
        end
        ref_mem = mem;
    endtask

    task automatic build_directed();
        bit [31:0] a;
        prog.delete(); mem.delete();
        prog.push_back(enc_i(OP_ADDI, 1, 0, 32'h10));          // 0  r1 = 0x10
        prog.push_back(enc_i(OP_LW, 2, 1, 32'h4));             // 1  r2 = M[0x14]
        prog.push_back(enc_i(OP_SW, 2, 0, 32'h0));             // 2  M[0] = r2
        prog.push_back(enc_i(OP_ADDI, 4, 0, 32'hFFFF));        // 3  r4 = -1
        prog.push_back(enc_i(OP_ADDI, 5, 0, 32'h1));           // 4  r5 = 1
        prog.push_back(enc_r(FN_SLT, 3, 4, 5));                // 5  r3 = 1
        prog.push_back(enc_r(FN_SUB, 6, 0, 5));                // 6  r6 = -1
        prog.push_back(enc_r(FN_ADD, 0, 1, 1));                // 7  r0 stays 0
        prog.push_back(enc_i(OP_BEQ, 1, 1, 32'h1));            // 8  taken, skip 9
        prog.push_back(enc_i(OP_ADDI, 7, 0, 32'h77));          // 9
        prog.push_back(enc_i(OP_BEQ, 2, 1, 32'h0));            // 10 not taken
        prog.push_back(enc_j(RST_PC + 32'd52));                // 11 -> 13
        prog.push_back(enc_i(OP_ADDI, 7, 0, 32'h55));          // 12
        prog.push_back(enc_r(FN_AND, 7, 1, 6));                // 13
        prog.push_back(enc_r(FN_OR, 7, 7, 5));                 // 14
        for (int r = 0; r < 8; r++) prog.push_back(enc_i(OP_SW, r, 0, 32'h900 + 32'(4 * r)));
        prog.push_back(32'hFC00_0000);
        a = 32'h14;
        mem[a[31:2]] = 32'hDEAD_BEEF;
        load_prog();
    endtask

    task automatic build_random();
        bit [5:0]  fns[5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        bit [31:0] a;
        prog.delete(); mem.delete();
        for (int r = 1; r < 8; r++) prog.push_back(enc_i(OP_ADDI, r, 0, $urandom));
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(5, 0))
                0: prog.push_back(enc_r(fns[$urandom_range(4, 0)], $urandom_range(7, 0),
                                        $urandom_range(7, 0), $urandom_range(7, 0)));
                1: prog.push_back(enc_i(OP_ADDI, $urandom_range(7, 0), $urandom_range(7, 0), $urandom));
                2: prog.push_back(enc_i(OP_LW, $urandom_range(7, 0), 0,
                                        32'h800 + 32'(4 * $urandom_range(7, 0) + $urandom_range(3, 0))));
                3: prog.push_back(enc_i(OP_SW, $urandom_range(7, 0), 0,
                                        32'h800 + 32'(4 * $urandom_range(7, 0) + $urandom_range(3, 0))));
                4: prog.push_back(enc_i(OP_BEQ, $urandom_range(7, 0), $urandom_range(7, 0),
                                        32'($urandom_range(2, 0))));
                default: prog.push_back(enc_j(RST_PC + 32'(4 * (prog.size() + 1 + $urandom_range(2, 0)))));
            endcase
        end
        for (int r = 1; r < 8; r++) prog.push_back(enc_i(OP_SW, r, 0, 32'h900 + 32'(4 * r)));
        prog.push_back(32'hFC00_0000);
        for (int k = 0; k < 8; k++) begin
            a = 32'h800 + 32'(4 * k);
            mem[a[31:2]] = $urandom;
        end
        load_prog();
    endtask

    // Memory responder with a random number of wait states per access.
    initial begin
        int remaining = -1;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (reset || !mif.mem_req) begin
                mif.mem_ready = 1'b0;
                remaining = -1;
            end else begin
                if (remaining < 0) remaining = $urandom_range(max_wait, 0);
                if (remaining == 0) begin
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = mem.exists(mif.mem_addr[31:2]) ? mem[mif.mem_addr[31:2]] : 32'd0;
                    if (mif.mem_we) mem[mif.mem_addr[31:2]] = mif.mem_wdata;
                    remaining = -1;
                end else begin
                    mif.mem_ready = 1'b0;
                    mif.mem_rdata = $urandom;
                    remaining--;
                end
            end
        end
    end

    // Monitor: handshake stability and completed accesses against the scoreboard.
    initial begin
        bit   pend = 1'b0;
        acc_t prev = '0;
        acc_t got;
        acc_t e;
        forever begin
            @(negedge clk);
            #1;
            got = '{mif.mem_we, mif.mem_addr, mif.mem_wdata};
            if (pend && mif.mem_req) begin
                check("hold_we", 32'(got.we), 32'(prev.we));
                check("hold_addr", got.addr, prev.addr);
                check("hold_wdata", got.wdata, prev.wdata);
            end
            if (mif.mem_req && mif.mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_access: got addr %h we %0d, expected no access", got.addr, got.we);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_we", 32'(got.we), 32'(e.we));
                    check("acc_addr", got.addr, e.addr);
                    if (e.we) check("acc_wdata", got.wdata, e.wdata);
                end
            end
            pend = mif.mem_req && !mif.mem_ready;
            prev = got;
        end
    end

    task automatic run_episode(input int mw, input bit lat_chk, input bit mid_rst);
        bit found = 1'b0;
        bit done  = 1'b0;
        reset = 1'b1;
        max_wait = mw;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("rst_req", 32'(mif.mem_req), 32'd0);
        check("rst_we", 32'(mif.mem_we), 32'd0);
        check("rst_addr", mif.mem_addr, RST_PC);
        check("rst_wdata", mif.mem_wdata, 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instret", instret, 32'd0);
        ref_run();
        @(posedge clk);
        #2 reset = 1'b0;
        if (lat_chk) begin
            repeat (4) @(negedge clk);
            #1 check("addi_lat_3cyc_instret", instret, 32'd0);
            @(negedge clk);
            #1;
            check("addi_lat_4cyc_instret", instret, 32'd1);
            check("addi_lat_4cyc_pc", pc, RST_PC + 32'd4);
        end
        if (mid_rst) begin
            for (int c = 0; c < 300 && !found; c++) begin
                @(posedge clk);
                #3;
                if (mif.mem_req && !mif.mem_we && (mif.mem_addr < RST_PC || mif.mem_addr >= 32'h800))
                    found = 1'b1;
            end
            if (!found) begin
                n_tests++; n_fail++;
                $display("FAIL midrst_timeout: got no load request, expected one within 300 cycles");
            end
            reset = 1'b1;
            #1;
            check("midrst_req", 32'(mif.mem_req), 32'd0);
            check("midrst_pc", pc, RST_PC);
            check("midrst_addr", mif.mem_addr, RST_PC);
            check("midrst_instret", instret, 32'd0);
            return;
        end
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            if (halted) done = 1'b1;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL halt_timeout: got halted=0, expected halt within 5000 cycles");
        end
        repeat (5) @(negedge clk);
        #1;
        check("queue_left", 32'(exp_q.size()), 32'd0);
        check("end_instret", instret, 32'(exp_ret));
        check("end_pc", pc, exp_pc);
        check("end_halted", 32'(halted), 32'd1);
        check("end_req", 32'(mif.mem_req), 32'd0);
    endtask

    initial begin
        build_directed();
        run_episode(0, 1'b1, 1'b0);
        build_directed();
        run_episode(3, 1'b0, 1'b1);
        build_directed();
        run_episode(2, 1'b0, 1'b0);
        for (int e = 0; e < 6; e++) begin
            build_random();
            run_episode(e % 4, 1'b0, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no completion, expected finish before 2000000 time units");
        $fatal(1, "bench timeout");
    end
endmodule
`default_nettype wire
